// File: rtl/arm_pkg.sv
// Shared types and constants for the MEM-stage SRAM controller.
// Holds the access FSM encoding, bus widths and the byte-address to SRAM-word mapping.
package arm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam int SRAM_ADDR_W = 18;
  localparam int SRAM_DATA_W = 16;
  localparam int WORD_W      = 32;
  localparam int SRAM_WORD_W = SRAM_ADDR_W - 1;

  localparam logic [WORD_W-1:0] DEFAULT_BASE_ADDR = 32'd1024;

  // 32-bit word index inside the SRAM; the subtraction wraps and the byte offset drops out.
  function automatic logic [SRAM_WORD_W-1:0] sram_word(input logic [WORD_W-1:0] addr,
                                                       input logic [WORD_W-1:0] base);
    return SRAM_WORD_W'((addr - base) >> 2);
  endfunction

endpackage

// File: rtl/sram_controller_if.sv
// MEM-stage side of the SRAM controller: request, address/data and the ready stall.
// The pipeline uses the master modport, the controller the slave modport.
interface sram_controller_if;
  import arm_pkg::*;

  logic              mem_r_en;
  logic              mem_w_en;
  logic [WORD_W-1:0] address;
  logic [WORD_W-1:0] wdata;
  logic [WORD_W-1:0] rdata;
  logic              ready;

  modport master (
    output mem_r_en,
    output mem_w_en,
    output address,
    output wdata,
    input  rdata,
    input  ready
  );

  modport slave (
    input  mem_r_en,
    input  mem_w_en,
    input  address,
    input  wdata,
    output rdata,
    output ready
  );

endinterface

// File: rtl/sram_controller_phase_timer.sv
// Loadable down-counter that measures one SRAM half-word phase of WAIT_CYCLES clocks.
// tc_o is high on the last cycle of the phase; load_i restarts the phase.
module sram_phase_timer #(
  parameter int WAIT_CYCLES = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int CNT_W = $clog2(WAIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(WAIT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = LOAD_VAL;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/sram_controller.sv
// Splits 32-bit MEM-stage loads/stores into low/high 16-bit SRAM phases and stalls via ready.
// Optional SRAM_CTRL_READ_HIT_EN adds a one-entry last-read buffer for single-cycle repeat loads.
//
// state | meaning
// IDLE  | waiting for a request; ready high when none is pending
// LOW   | low half-word phase, SRAM_ADDR = {word,0}
// HIGH  | high half-word phase, SRAM_ADDR = {word,1}
// DONE  | access complete, ready high, rdata valid
module sram_controller
  import arm_pkg::*;
#(
  parameter int                WAIT_CYCLES = 3,
  parameter logic [WORD_W-1:0] BASE_ADDR   = DEFAULT_BASE_ADDR
) (
  input  logic                   clk,
  input  logic                   rst,
  sram_controller_if.slave       bus,
  inout  wire  [SRAM_DATA_W-1:0] SRAM_DQ,
  output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
  output logic                   SRAM_UB_N,
  output logic                   SRAM_LB_N,
  output logic                   SRAM_WE_N,
  output logic                   SRAM_CE_N,
  output logic                   SRAM_OE_N
);

  state_e                 state_q, state_d;
  logic                   wr_q, wr_d;
  logic [SRAM_WORD_W-1:0] word_q, word_d;
  logic [WORD_W-1:0]      wdata_q, wdata_d;
  logic [WORD_W-1:0]      rdata_q, rdata_d;

  logic                   req;
  logic [SRAM_WORD_W-1:0] req_word;
  logic                   timer_load;
  logic                   timer_en;
  logic                   timer_tc;
  logic [SRAM_DATA_W-1:0] dq_out;

`ifdef SRAM_CTRL_READ_HIT_EN
  logic                   hit_valid_q;
  logic [SRAM_WORD_W-1:0] hit_tag_q;
  logic [WORD_W-1:0]      hit_data_q;
  logic                   hit;
`endif

  assign req      = bus.mem_r_en | bus.mem_w_en;
  assign req_word = sram_word(bus.address, BASE_ADDR);

  sram_phase_timer #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .load_i(timer_load),
    .en_i  (timer_en),
    .tc_o  (timer_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wr_q    <= 1'b0;
      word_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      word_q  <= word_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wr_d       = wr_q;
    word_d     = word_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    timer_load = 1'b0;
    timer_en   = 1'b0;
`ifdef SRAM_CTRL_READ_HIT_EN
    hit        = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (req) begin
          word_d  = req_word;
          wr_d    = bus.mem_w_en;
          wdata_d = bus.wdata;
`ifdef SRAM_CTRL_READ_HIT_EN
          hit = ~bus.mem_w_en & hit_valid_q & (hit_tag_q == req_word);
          if (hit) begin
            rdata_d = hit_data_q;
            state_d = DONE;
          end else begin
            timer_load = 1'b1;
            state_d    = LOW;
          end
`else
          timer_load = 1'b1;
          state_d    = LOW;
`endif
        end
      end
      LOW: begin
        timer_en = 1'b1;
        if (timer_tc) begin
          if (!wr_q) rdata_d[15:0] = SRAM_DQ;
          timer_load = 1'b1;
          state_d    = HIGH;
        end
      end
      HIGH: begin
        timer_en = 1'b1;
        if (timer_tc) begin
          if (!wr_q) rdata_d[31:16] = SRAM_DQ;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

`ifdef SRAM_CTRL_READ_HIT_EN
  // Refreshed at DONE so the buffer only ever holds a fully completed read.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_valid_q <= 1'b0;
      hit_tag_q   <= '0;
      hit_data_q  <= '0;
    end else if (state_q == DONE) begin
      if (!wr_q) begin
        hit_valid_q <= 1'b1;
        hit_tag_q   <= word_q;
        hit_data_q  <= rdata_q;
      end else if (hit_tag_q == word_q) begin
        hit_valid_q <= 1'b0;
      end
    end
  end
`endif

  always_comb begin
    SRAM_ADDR = '0;
    if (state_q == LOW)  SRAM_ADDR = {word_q, 1'b0};
    if (state_q == HIGH) SRAM_ADDR = {word_q, 1'b1};
  end

  assign SRAM_WE_N = ~(wr_q & ((state_q == LOW) | (state_q == HIGH)));
  assign dq_out    = (state_q == HIGH) ? wdata_q[31:16] : wdata_q[15:0];
  assign SRAM_DQ   = SRAM_WE_N ? {SRAM_DATA_W{1'bz}} : dq_out;

  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_OE_N = 1'b0;

  assign bus.ready = ((state_q == IDLE) & ~req) | (state_q == DONE);
  assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_sram_controller.sv
// Self-checking bench for sram_controller: vector table, corner sequences and random traffic
// against a word-level memory model. Build with SRAM_CTRL_READ_HIT_EN to cover the hit buffer.
module tb_sram_controller;
  import arm_pkg::*;

  localparam int W   = 3;
  localparam int LAT = 2 * W + 1;
`ifdef SRAM_CTRL_READ_HIT_EN
  localparam int HIT_LAT = 1;
`else
  localparam int HIT_LAT = LAT;
`endif

  logic        clk = 1'b0;
  logic        rst;
  wire  [15:0] SRAM_DQ;
  logic [17:0] SRAM_ADDR;
  logic        SRAM_UB_N, SRAM_LB_N, SRAM_WE_N, SRAM_CE_N, SRAM_OE_N;

  sram_controller_if bus ();

  sram_controller #(
    .WAIT_CYCLES(W),
    .BASE_ADDR  (32'd1024)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .SRAM_DQ  (SRAM_DQ),
    .SRAM_ADDR(SRAM_ADDR),
    .SRAM_UB_N(SRAM_UB_N),
    .SRAM_LB_N(SRAM_LB_N),
    .SRAM_WE_N(SRAM_WE_N),
    .SRAM_CE_N(SRAM_CE_N),
    .SRAM_OE_N(SRAM_OE_N)
  );

  always #5 clk = ~clk;

  // SRAM device: drives the bus whenever not being written (OE_N/CE_N are tied low).
  logic [15:0] mem [0:4095];
  logic [15:0] sram_out;
  logic        mem_clr;
  assign sram_out = mem[SRAM_ADDR[11:0]];
  assign SRAM_DQ  = SRAM_WE_N ? sram_out : 16'hzzzz;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 4096; i++) mem[i] <= '0;
    end else if (!SRAM_WE_N) begin
      mem[SRAM_ADDR[11:0]] <= SRAM_DQ;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: 32-bit words, last load result, last-read buffer.
  logic [31:0] m_words [0:2047];
  logic [31:0] m_rdata;
  bit          c_valid;
  logic [16:0] c_tag;

  task automatic model_step(input bit r, input bit w, input logic [31:0] addr,
                            input logic [31:0] wd, output int lat, output logic [31:0] rd);
    logic [31:0] eff;
    logic [16:0] word;
    bit          hit;
    eff  = addr - 32'd1024;
    word = eff[18:2];
    lat  = LAT;
    if (w) begin
      m_words[word[10:0]] = wd;
      if (c_valid && c_tag == word) c_valid = 0;
    end else if (r) begin
      hit = c_valid && (c_tag == word) && (HIT_LAT == 1);
      if (hit) lat = HIT_LAT;
      m_rdata = m_words[word[10:0]];
      c_valid = 1;
      c_tag   = word;
    end
    rd = m_rdata;
  endtask

  // Starts at a negedge with the controller idle, ends at a negedge with it idle again.
  task automatic do_access(input bit r, input bit w, input logic [31:0] addr,
                           input logic [31:0] wd, input bit scramble,
                           output int lat, output logic [31:0] rd, output bit addr_act);
    bus.mem_r_en = r;
    bus.mem_w_en = w;
    bus.address  = addr;
    bus.wdata    = wd;
    addr_act = 0;
    lat      = 0;
    #1;
    chk("ready_cycle0", {31'd0, bus.ready}, 32'd0);
    while (!bus.ready && lat < 40) begin
      @(negedge clk);
      lat++;
      if (SRAM_ADDR != '0 || !SRAM_WE_N) addr_act = 1;
      if (SRAM_WE_N) chk("dq_released", {16'd0, SRAM_DQ}, {16'd0, sram_out});
      if (scramble && lat == 1 && !bus.ready) begin
        bus.mem_r_en = 1'($urandom);
        bus.mem_w_en = 1'($urandom);
        bus.address  = $urandom;
        bus.wdata    = $urandom;
      end
    end
    rd = bus.rdata;
    bus.mem_r_en = 0;
    bus.mem_w_en = 0;
    @(negedge clk);
    chk("idle_ready", {31'd0, bus.ready}, 32'd1);
    chk("idle_we_n", {31'd0, SRAM_WE_N}, 32'd1);
  endtask

  typedef struct {
    bit          r;
    bit          w;
    logic [31:0] addr;
    logic [31:0] wd;
    int          lat;
    logic [31:0] rd;
  } vec_t;

  vec_t vecs [6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          lat, elat;
    logic [31:0] rd, erd;
    bit          act;

    vecs[0] = '{r: 0, w: 1, addr: 32'd1024, wd: 32'hDEADBEEF, lat: 7, rd: 32'h0};
    vecs[1] = '{r: 1, w: 0, addr: 32'd1024, wd: 32'h0,        lat: 7, rd: 32'hDEADBEEF};
    vecs[2] = '{r: 0, w: 1, addr: 32'd1032, wd: 32'h12345678, lat: 7, rd: 32'hDEADBEEF};
    vecs[3] = '{r: 1, w: 0, addr: 32'd1032, wd: 32'h0,        lat: 7, rd: 32'h12345678};
    vecs[4] = '{r: 1, w: 1, addr: 32'd1028, wd: 32'h0000AAAA, lat: 7, rd: 32'h12345678};
    vecs[5] = '{r: 1, w: 0, addr: 32'd1030, wd: 32'h0,        lat: 7, rd: 32'h0000AAAA};

    for (int i = 0; i < 2048; i++) m_words[i] = '0;
    m_rdata = '0;
    c_valid = 0;
    c_tag   = '0;

    rst = 1;
    mem_clr = 1;
    bus.mem_r_en = 0;
    bus.mem_w_en = 0;
    bus.address  = '0;
    bus.wdata    = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, bus.ready}, 32'd1);
    chk("rst_we_n", {31'd0, SRAM_WE_N}, 32'd1);
    chk("rst_addr", {14'd0, SRAM_ADDR}, 32'd0);
    chk("rst_rdata", bus.rdata, 32'd0);
    chk("rst_dq", {16'd0, SRAM_DQ}, {16'd0, sram_out});
    rst = 0;
    mem_clr = 0;
    @(negedge clk);

    foreach (vecs[i]) begin
      model_step(vecs[i].r, vecs[i].w, vecs[i].addr, vecs[i].wd, elat, erd);
      do_access(vecs[i].r, vecs[i].w, vecs[i].addr, vecs[i].wd, 1'b0, lat, rd, act);
      chk($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      chk($sformatf("vec%0d_rdata", i), rd, vecs[i].rd);
    end

    chk("mem0", {16'd0, mem[0]}, 32'hBEEF);
    chk("mem1", {16'd0, mem[1]}, 32'hDEAD);
    chk("mem2", {16'd0, mem[2]}, 32'hAAAA);
    chk("mem3", {16'd0, mem[3]}, 32'h0000);
    chk("mem4", {16'd0, mem[4]}, 32'h5678);
    chk("mem5", {16'd0, mem[5]}, 32'h1234);
    chk("mem6_untouched", {16'd0, mem[6]}, 32'h0000);

    // Reset in the second HIGH cycle of a store.
    bus.mem_w_en = 1;
    bus.address  = 32'd1040;
    bus.wdata    = 32'h11112222;
    repeat (5) @(negedge clk);
    chk("midwr_we_n", {31'd0, SRAM_WE_N}, 32'd0);
    chk("midwr_addr", {14'd0, SRAM_ADDR}, 32'd9);
    rst = 1;
    bus.mem_w_en = 0;
    @(negedge clk);
    chk("midwr_rst_ready", {31'd0, bus.ready}, 32'd1);
    chk("midwr_rst_we_n", {31'd0, SRAM_WE_N}, 32'd1);
    chk("midwr_rst_addr", {14'd0, SRAM_ADDR}, 32'd0);
    chk("midwr_rst_dq", {16'd0, SRAM_DQ}, {16'd0, sram_out});
    chk("midwr_rst_rdata", bus.rdata, 32'd0);
    rst = 0;
    m_rdata = '0;
    c_valid = 0;
    model_step(1, 0, 32'd1024, 32'd0, elat, erd);
    do_access(1, 0, 32'd1024, 32'd0, 1'b0, lat, rd, act);
    chk("post_rst_load_latency", lat, 7);
    chk("post_rst_load_rdata", rd, 32'hDEADBEEF);

    // Repeat load, then store to the same word and load again.
    model_step(1, 0, 32'd1024, 32'd0, elat, erd);
    do_access(1, 0, 32'd1024, 32'd0, 1'b0, lat, rd, act);
    chk("repeat_load_latency", lat, HIT_LAT);
    chk("repeat_load_rdata", rd, 32'hDEADBEEF);
`ifdef SRAM_CTRL_READ_HIT_EN
    chk("repeat_load_no_sram", {31'd0, act}, 32'd0);
`else
    chk("repeat_load_sram_used", {31'd0, act}, 32'd1);
`endif
    model_step(0, 1, 32'd1024, 32'hCAFEF00D, elat, erd);
    do_access(0, 1, 32'd1024, 32'hCAFEF00D, 1'b0, lat, rd, act);
    chk("store_after_hit_latency", lat, 7);
    model_step(1, 0, 32'd1024, 32'd0, elat, erd);
    do_access(1, 0, 32'd1024, 32'd0, 1'b0, lat, rd, act);
    chk("load_after_store_latency", lat, 7);
    chk("load_after_store_rdata", rd, 32'hCAFEF00D);

    for (int i = 0; i < 80; i++) begin
      int          word;
      int          op;
      bit          r, w;
      logic [31:0] addr, wd;
      word = $urandom_range(16, 24);
      op   = $urandom_range(0, 3);
      r    = (op != 2);
      w    = (op >= 2);
      addr = 32'd1024 + 32'(word * 4) + 32'($urandom_range(0, 3));
      wd   = $urandom;
      model_step(r, w, addr, wd, elat, erd);
      do_access(r, w, addr, wd, 1'b1, lat, rd, act);
      chk($sformatf("rand%0d_latency", i), lat, elat);
      chk($sformatf("rand%0d_rdata", i), rd, erd);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
